zap_branch_predict_ctrl: RTL

Bimodal branch-history controller that owns the 2-bit prediction table feeding the predecode stage's `i_taken`. It sits beside fetch. It looks up a prediction state for every fetched PC and returns it one cycle later, aligned with the fetched instruction. It writes back saturating-counter updates when branches resolve downstream. After reset it sweeps the table to a known state before accepting updates.

---
 rtl/zap_branch_predict_ctrl_pkg.sv | 50 +++++
 rtl/zap_branch_predict_ctrl_if.sv | 36 +++
 rtl/zap_bp_ram.sv | 23 ++
 rtl/zap_branch_predict_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/zap_branch_predict_ctrl_pkg.sv
// Shared prediction-state constants and index/saturation helpers.
// Build option: ZAP_BP_FWD_EN (same-cycle update forwarding in the top).
package zap_branch_predict_ctrl_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic {
    S_INIT,
    S_RUN
  } fsm_t;

  typedef enum logic [1:0] {
    SRC_SNT,
    SRC_WNT,
    SRC_RAM,
    SRC_FWD
  } src_t;

  function automatic logic [1:0] sat_inc(
    input logic [1:0] s
  );
    return (s == ST) ? ST : s + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(
    input logic [1:0] s
  );
    return (s == SNT) ? SNT : s - 2'd1;
  endfunction

  function automatic logic [1:0] bp_next(
    input logic [1:0] s,
    input logic       taken
  );
    return taken ? sat_inc(s) : sat_dec(s);
  endfunction

  // Halfword-aligned in compressed mode, word-aligned otherwise.
  function automatic logic [31:0] bp_idx(
    input logic [31:0] pc,
    input logic        t
  );
    return t ? {1'b0, pc[31:1]}
             : {2'b0, pc[31:2]};
  endfunction

endpackage

// File: rtl/zap_branch_predict_ctrl_if.sv
// Fetch-lookup / branch-update bundle of the bimodal predictor.
// Build option: ZAP_BP_FWD_EN (no signals depend on it).
interface zap_branch_predict_ctrl_if;

  logic [31:0] i_fetch_pc;
  logic        i_fetch_t;
  logic        i_fetch_valid;
  logic        i_stall;
  logic        i_clear;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_t;
  logic [1:0]  i_upd_state;
  logic        i_upd_taken;
  logic [1:0]  o_taken_ff;
  logic        o_init_busy;

  modport master (
    output i_fetch_pc, i_fetch_t,
    output i_fetch_valid, i_stall,
    output i_clear, i_upd_valid,
    output i_upd_pc, i_upd_t,
    output i_upd_state, i_upd_taken,
    input  o_taken_ff, o_init_busy
  );

  modport slave (
    input  i_fetch_pc, i_fetch_t,
    input  i_fetch_valid, i_stall,
    input  i_clear, i_upd_valid,
    input  i_upd_pc, i_upd_t,
    input  i_upd_state, i_upd_taken,
    output o_taken_ff, o_init_busy
  );

endinterface

// File: rtl/zap_bp_ram.sv
// 1W1R sync-read 2-bit table, read-before-write on address collision.
// Build option: ZAP_BP_FWD_EN (not used here).
module zap_bp_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/zap_branch_predict_ctrl.sv
// Bimodal predictor controller: init sweep, lookup, saturating update.
// Build option: ZAP_BP_FWD_EN forwards a same-index update to the lookup.
module zap_branch_predict_ctrl
  import zap_branch_predict_ctrl_pkg::*;
#(
  parameter int BP_ENTRIES = 1024,
  parameter int IDX_W      = $clog2(BP_ENTRIES)
) (
  input logic                      i_clk,
  input logic                      i_reset,
  zap_branch_predict_ctrl_if.slave bp
);

  fsm_t             state_q;
  fsm_t             state_d;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] up_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       up_next;
  logic [1:0]       wr_data;
  logic [1:0]       rd_data;
  logic [1:0]       taken;
  logic             wr_en;
  logic             rd_en;
  logic             upd_ok;
  logic             init_busy;
  src_t             src_q;

  assign rd_idx  = IDX_W'(bp_idx(bp.i_fetch_pc, bp.i_fetch_t));
  assign up_idx  = IDX_W'(bp_idx(bp.i_upd_pc, bp.i_upd_t));
  assign up_next = bp_next(bp.i_upd_state, bp.i_upd_taken);
  assign upd_ok  = (state_q == S_RUN) & bp.i_upd_valid & ~i_reset;
  // Read port frozen on stall so the held prediction survives.
  assign rd_en   = bp.i_fetch_valid & ~bp.i_stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                cnt_q <= '0;
    else if (state_q == S_INIT) cnt_q <= cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT:  if (cnt_q == '1) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    init_busy = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = cnt_q;
    wr_data   = WNT;
    unique case (state_q)
      S_INIT: begin
        init_busy = 1'b1;
        wr_en     = ~i_reset;
      end
      S_RUN: begin
        wr_en   = upd_ok;
        wr_idx  = up_idx;
        wr_data = up_next;
      end
      default: ;
    endcase
  end

`ifdef ZAP_BP_FWD_EN
  logic       same_idx;
  logic [1:0] fwd_q;

  assign same_idx = upd_ok & (rd_idx == up_idx);

  always_ff @(posedge i_clk) begin
    if (rd_en & same_idx) fwd_q <= up_next;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset | bp.i_clear) begin
      src_q <= SRC_SNT;
    end else if (!bp.i_stall) begin
      if (!bp.i_fetch_valid)      src_q <= SRC_SNT;
      else if (state_q == S_INIT) src_q <= SRC_WNT;
`ifdef ZAP_BP_FWD_EN
      else if (same_idx)          src_q <= SRC_FWD;
`endif
      else                        src_q <= SRC_RAM;
    end
  end

  always_comb begin
    taken = SNT;
    unique case (src_q)
      SRC_SNT: taken = SNT;
      SRC_WNT: taken = WNT;
      SRC_RAM: taken = rd_data;
`ifdef ZAP_BP_FWD_EN
      SRC_FWD: taken = fwd_q;
`else
      SRC_FWD: taken = SNT;
`endif
      default: taken = SNT;
    endcase
  end

  assign bp.o_taken_ff  = taken;
  assign bp.o_init_busy = init_busy;

  zap_bp_ram #(
    .DEPTH (BP_ENTRIES),
    .AW    (IDX_W)
  ) u_ram (
    .i_clk (i_clk),
    .we    (wr_en),
    .waddr (wr_idx),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

endmodule
